// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader: FSM state encoding and frame constants.
package loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN0 = 3'd1,
        ST_LEN1 = 3'd2,
        ST_DATA = 3'd3,
        ST_CSUM = 3'd4,
        ST_DONE = 3'd5,
        ST_ERR  = 3'd6
    } state_e;

    localparam logic [7:0]  MAGIC_DEFAULT = 8'hA5;
    localparam int unsigned HDR_LEN       = 3;
    localparam int unsigned BYTE_W        = 8;
    localparam int unsigned WORD_W        = 32;

endpackage

// File: rtl/prog_loader_word_assembler.sv
// Little-endian byte-to-word shift register with a 2-bit byte counter; word_full marks the 4th byte.
module word_assembler
    import loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              shift_en,
    input  logic              clear,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [WORD_W-1:0] word_out,
    output logic              word_full
);

    logic [1:0]        cnt_q, cnt_d;
    logic [WORD_W-1:0] word_q, word_d;

    // New bytes enter at the top so the first byte of a word ends up in bits[7:0].
    always_comb begin
        cnt_d  = cnt_q;
        word_d = word_q;
        if (clear) begin
            cnt_d  = 2'd0;
            word_d = '0;
        end else if (shift_en) begin
            cnt_d  = cnt_q + 2'd1;
            word_d = {byte_in, word_q[WORD_W-1:BYTE_W]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= 2'd0;
            word_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
        end
    end

    assign word_out  = word_q;
    assign word_full = shift_en && (cnt_q == 2'd3);

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream program loader: writes 32-bit words to instruction memory and holds the CPU
// in reset until the image checksum is verified.
module prog_loader
    import loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DEPTH  = 256,
    parameter logic [7:0]  MAGIC  = MAGIC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              cpu_rst_hold,
    output logic              done,
    output logic              error
);

    localparam int unsigned IDX_W = ADDR_W - 2;

    state_e              state_q, state_d;
    logic [15:0]         len_q, len_d;
    logic [IDX_W-1:0]    widx_q, widx_d;
    logic [BYTE_W-1:0]   csum_q, csum_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                ready_q, ready_d;
    logic                hold_q, hold_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                xfer;
    logic                shift_en;
    logic                word_full;
    logic [15:0]         len_full;

    assign xfer     = in_valid && ready_q;
    assign shift_en = xfer && (state_q == ST_DATA);
    assign len_full = {in_data, len_q[7:0]};

    word_assembler u_asm (
        .clk      (clk),
        .rst      (rst),
        .shift_en (shift_en),
        .clear    (state_q == ST_IDLE),
        .byte_in  (in_data),
        .word_out (imem_wdata),
        .word_full(word_full)
    );

    // Next-state and output decode.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        widx_d  = widx_q;
        csum_d  = csum_q;
        we_d    = 1'b0;
        addr_d  = addr_q;

        unique case (state_q)
            ST_IDLE: begin
                if (xfer && (in_data == MAGIC)) begin
                    state_d = ST_LEN0;
                    len_d   = '0;
                    widx_d  = '0;
                    csum_d  = '0;
                end
            end
            ST_LEN0: begin
                if (xfer) begin
                    len_d   = {8'h00, in_data};
                    state_d = ST_LEN1;
                end
            end
            ST_LEN1: begin
                if (xfer) begin
                    len_d = len_full;
                    if (len_full > 16'(DEPTH)) begin
                        state_d = ST_ERR;
                    end else if (len_full == 16'd0) begin
                        state_d = ST_CSUM;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (xfer) begin
                    csum_d = csum_q ^ in_data;
                    if (word_full) begin
                        we_d   = 1'b1;
                        addr_d = {widx_q, 2'b00};
                        // Index stops at N-1 so it never wraps when N == DEPTH.
                        if (16'(widx_q) == (len_q - 16'd1)) begin
                            state_d = ST_CSUM;
                        end else begin
                            widx_d = widx_q + IDX_W'(1);
                        end
                    end
                end
            end
            ST_CSUM: begin
                if (xfer) begin
                    state_d = (in_data == csum_q) ? ST_DONE : ST_ERR;
                end
            end
            ST_DONE: state_d = ST_DONE;
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_IDLE;
        endcase

        ready_d = !((state_d == ST_DONE) || (state_d == ST_ERR));
        done_d  = (state_d == ST_DONE);
        err_d   = (state_d == ST_ERR);
        hold_d  = (state_d != ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            widx_q  <= '0;
            csum_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            ready_q <= 1'b1;
            hold_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            widx_q  <= widx_d;
            csum_q  <= csum_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            ready_q <= ready_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign in_ready     = ready_q;
    assign imem_we      = we_q;
    assign imem_addr    = addr_q;
    assign cpu_rst_hold = hold_q;
    assign done         = done_q;
    assign error        = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader: frame loads, garbage skip, checksum/length errors,
// mid-load reset and the empty image.
module tb_prog_loader;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        imem_we;
    logic [9:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_rst_hold;
    logic        done;
    logic        error;

    int tests;
    int fails;

    logic [9:0]  wr_addr[$];
    logic [31:0] wr_data[$];
    logic        we_prev;
    int          we_double;

    typedef logic [7:0] bytes_t[$];

    prog_loader dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .imem_we     (imem_we),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .cpu_rst_hold(cpu_rst_hold),
        .done        (done),
        .error       (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write log sampled mid-cycle, plus a count of back-to-back strobes.
    always @(negedge clk) begin
        if (imem_we) begin
            wr_addr.push_back(imem_addr);
            wr_data.push_back(imem_wdata);
            if (we_prev) we_double++;
        end
        we_prev = imem_we;
    end

    task automatic send_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_bytes(input bytes_t q);
        foreach (q[i]) send_byte(q[i]);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        wr_addr.delete();
        wr_data.delete();
        we_double = 0;
        @(negedge clk);
    endtask

    task automatic check_writes(input string name, input int n, input logic [9:0] a0,
                                input logic [31:0] d0, input logic [9:0] a1, input logic [31:0] d1);
        tests++;
        if (wr_addr.size() != n) begin
            fails++;
            $display("FAIL %s: write count got %0d expected %0d", name, wr_addr.size(), n);
        end else begin
            if (n > 0 && (wr_addr[0] !== a0 || wr_data[0] !== d0)) begin
                fails++;
                $display("FAIL %s: write0 got %h@%h expected %h@%h", name, wr_data[0], wr_addr[0], d0, a0);
            end
            if (n > 1 && (wr_addr[1] !== a1 || wr_data[1] !== d1)) begin
                fails++;
                $display("FAIL %s: write1 got %h@%h expected %h@%h", name, wr_data[1], wr_addr[1], d1, a1);
            end
        end
        tests++;
        if (we_double !== 0) begin
            fails++;
            $display("FAIL %s: imem_we high consecutive cycles %0d times expected 0", name, we_double);
        end
    endtask

    task automatic check_status(input string name, input logic e_rdy, input logic e_hold,
                                input logic e_done, input logic e_err);
        tests++;
        if ({in_ready, cpu_rst_hold, done, error} !== {e_rdy, e_hold, e_done, e_err}) begin
            fails++;
            $display("FAIL %s: {rdy,hold,done,err} got %b%b%b%b expected %b%b%b%b", name,
                     in_ready, cpu_rst_hold, done, error, e_rdy, e_hold, e_done, e_err);
        end
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if ({in_ready, imem_we, imem_addr, imem_wdata, cpu_rst_hold, done, error} !==
            {1'b1, 1'b0, 10'h0, 32'h0, 1'b1, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL reset: rdy=%b we=%b addr=%h wdata=%h hold=%b done=%b err=%b",
                     in_ready, imem_we, imem_addr, imem_wdata, cpu_rst_hold, done, error);
        end
    endtask

    // Payload XOR: (13^00^A0^E3)=50, (01^10^81^E2)=72, 50^72=22.
    task automatic test_two_words();
        do_reset();
        send_bytes('{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'hA0, 8'hE3, 8'h01, 8'h10, 8'h81, 8'hE2});
        tests++;
        if (imem_we !== 1'b1 || imem_addr !== 10'h004 || imem_wdata !== 32'hE2811001 || cpu_rst_hold !== 1'b1) begin
            fails++;
            $display("FAIL last_write_cycle: we=%b addr=%h wdata=%h hold=%b expected 1 004 e2811001 1",
                     imem_we, imem_addr, imem_wdata, cpu_rst_hold);
        end
        send_byte(8'h22);
        check_status("two_words_done", 1'b0, 1'b0, 1'b1, 1'b0);
        check_writes("two_words", 2, 10'h000, 32'hE3A00013, 10'h004, 32'hE2811001);
    endtask

    task automatic test_garbage();
        do_reset();
        // Payload 78 56 34 12 -> XOR = 08.
        send_bytes('{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08});
        check_status("garbage_done", 1'b0, 1'b0, 1'b1, 1'b0);
        check_writes("garbage", 1, 10'h000, 32'h12345678, 10'h000, 32'h0);
    endtask

    task automatic test_bad_csum();
        do_reset();
        send_bytes('{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'hA0, 8'hE3, 8'h01, 8'h10, 8'h81, 8'hE2, 8'h21});
        check_status("bad_csum", 1'b0, 1'b1, 1'b0, 1'b1);
        check_writes("bad_csum", 2, 10'h000, 32'hE3A00013, 10'h004, 32'hE2811001);
    endtask

    task automatic test_too_long();
        do_reset();
        send_bytes('{8'hA5, 8'h01, 8'h01});
        check_status("too_long", 1'b0, 1'b1, 1'b0, 1'b1);
        send_bytes('{8'h13, 8'h00, 8'hA0, 8'hE3});
        check_status("too_long_ignored", 1'b0, 1'b1, 1'b0, 1'b1);
        check_writes("too_long", 0, 10'h0, 32'h0, 10'h0, 32'h0);
    endtask

    task automatic test_max_len();
        do_reset();
        // N = 256 == DEPTH is legal: after header the loader is still accepting payload.
        send_bytes('{8'hA5, 8'h00, 8'h01, 8'hAA});
        check_status("max_len", 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_mid_reset();
        do_reset();
        send_bytes('{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'hA0, 8'hE3, 8'h01, 8'h10});
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests++;
        if ({in_ready, imem_we, imem_addr, imem_wdata, cpu_rst_hold, done, error} !==
            {1'b1, 1'b0, 10'h0, 32'h0, 1'b1, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL mid_reset_outputs: rdy=%b we=%b addr=%h wdata=%h hold=%b done=%b err=%b",
                     in_ready, imem_we, imem_addr, imem_wdata, cpu_rst_hold, done, error);
        end
        check_writes("mid_reset_partial", 1, 10'h000, 32'hE3A00013, 10'h0, 32'h0);
        wr_addr.delete();
        wr_data.delete();
        send_bytes('{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'hA0, 8'hE3, 8'h01, 8'h10, 8'h81, 8'hE2, 8'h22});
        check_status("mid_reset_reload", 1'b0, 1'b0, 1'b1, 1'b0);
        check_writes("mid_reset_reload", 2, 10'h000, 32'hE3A00013, 10'h004, 32'hE2811001);
    endtask

    task automatic test_empty();
        do_reset();
        send_bytes('{8'hA5, 8'h00, 8'h00, 8'h00});
        check_status("empty_done", 1'b0, 1'b0, 1'b1, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'hA5;
        repeat (5) @(negedge clk);
        in_valid = 1'b0;
        check_status("empty_hold_valid", 1'b0, 1'b0, 1'b1, 1'b0);
        check_writes("empty", 0, 10'h0, 32'h0, 10'h0, 32'h0);
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        we_prev   = 1'b0;
        we_double = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        test_reset();
        test_two_words();
        test_garbage();
        test_bad_csum();
        test_too_long();
        test_max_len();
        test_mid_reset();
        test_empty();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
